// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared state, geometry and pixel types for the LED matrix scan path
package led_matrix_pkg;

   // Default panel geometry: 64 columns, 1/16 scan
   localparam int DEF_COLS     = 64;
   localparam int DEF_ROW_BITS = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_t;

   // Upper-half and lower-half pixel bits for one (col,row) coordinate
   typedef struct packed {
      logic r0;
      logic g0;
      logic b0;
      logic r1;
      logic g1;
      logic b1;
   } rgb_pair_t;

   // On-time for a brightness level: eighths of the full on-time
   function automatic int unsigned bright_cycles(input int unsigned on_cyc, input logic [2:0] level);
      return (on_cyc >> 3) * (32'(level) + 32'd1);
   endfunction

endpackage

// File: rtl/led_clk_phase.sv
// rtl/led_clk_phase.sv - per-column phase counter producing capture, panel clock rise and column step strobes
module led_clk_phase #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic run_i,
   output logic ph_zero_o,
   output logic clk_rise_o,
   output logic col_step_o
);

   localparam int              PH_W    = $clog2(2 * CLK_DIV);
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);

   logic [PH_W-1:0] ph_q;
   logic [PH_W-1:0] ph_d;

   // Count through one column period while running; park at zero otherwise
   always_comb begin
      ph_d = '0;
      if (run_i && (ph_q != PH_LAST)) begin
         ph_d = ph_q + 1'b1;
      end
   end

   // Phase register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ph_q <= '0;
      end else begin
         ph_q <= ph_d;
      end
   end

   // Strobes describe what the owner should register at the end of this cycle
   assign ph_zero_o  = run_i && (ph_q == '0);
   assign clk_rise_o = run_i && (ph_q == PH_RISE);
   assign col_step_o = run_i && (ph_q == PH_LAST);

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - HUB75 row-sequential scan driver; LED_MATRIX_BRIGHT_EN adds a 3-bit brightness input
module led_matrix_scan
   import led_matrix_pkg::*;
#(
   parameter int COLS     = DEF_COLS,
   parameter int ROW_BITS = DEF_ROW_BITS,
   parameter int CLK_DIV  = 2,
   parameter int LAT_CYC  = 2,
   parameter int ON_CYC   = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
`ifdef LED_MATRIX_BRIGHT_EN
   input  logic [2:0]               brightness,
`endif
   output logic [$clog2(COLS)-1:0]  col,
   output logic [ROW_BITS-1:0]      row,
   input  logic                     R0,
   input  logic                     G0,
   input  logic                     B0,
   input  logic                     R1,
   input  logic                     G1,
   input  logic                     B1,
   output logic                     panel_r0,
   output logic                     panel_g0,
   output logic                     panel_b0,
   output logic                     panel_r1,
   output logic                     panel_g1,
   output logic                     panel_b1,
   output logic                     panel_clk,
   output logic                     panel_lat,
   output logic                     panel_oe_n,
   output logic [ROW_BITS-1:0]      panel_addr,
   output logic                     frame_done
);

   localparam int                  COL_W    = $clog2(COLS);
   localparam int                  CNT_MAX  = (ON_CYC > LAT_CYC) ? ON_CYC : LAT_CYC;
   localparam int                  CNT_W    = $clog2(CNT_MAX);
   localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
   localparam logic [CNT_W-1:0]    LAT_LAST = CNT_W'(LAT_CYC - 1);

   scan_state_t         state_q;
   logic [COL_W-1:0]    col_q;
   logic [ROW_BITS-1:0] row_q;
   rgb_pair_t           data_q;
   logic                panel_clk_q;
   logic                panel_lat_q;
   logic                panel_oe_n_q;
   logic [ROW_BITS-1:0] panel_addr_q;
   logic                frame_done_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    on_last;

   logic ph_zero;
   logic clk_rise;
   logic col_step;

`ifdef LED_MATRIX_BRIGHT_EN
   logic [CNT_W-1:0] on_last_q;
   assign on_last = on_last_q;
`else
   assign on_last = CNT_W'(ON_CYC - 1);
`endif

   led_clk_phase #(
      .CLK_DIV (CLK_DIV)
   ) u_phase (
      .clk_i      (clk),
      .rst_ni     (rst),
      .run_i      (state_q == ST_SHIFT),
      .ph_zero_o  (ph_zero),
      .clk_rise_o (clk_rise),
      .col_step_o (col_step)
   );

   // Scan sequencer: shift a row, blank, latch, display, advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         data_q       <= '0;
         panel_clk_q  <= 1'b0;
         panel_lat_q  <= 1'b0;
         panel_oe_n_q <= 1'b1;
         panel_addr_q <= '0;
         frame_done_q <= 1'b0;
         cnt_q        <= '0;
`ifdef LED_MATRIX_BRIGHT_EN
         on_last_q    <= '0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               panel_oe_n_q <= 1'b1;
               panel_lat_q  <= 1'b0;
               panel_clk_q  <= 1'b0;
               col_q        <= '0;
               if (en) begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Pixel generator is combinational on col/row, so sample directly
               if (ph_zero) begin
                  data_q <= '{r0: R0, g0: G0, b0: B0, r1: R1, g1: G1, b1: B1};
               end
               if (clk_rise) begin
                  panel_clk_q <= 1'b1;
               end
               if (col_step) begin
                  panel_clk_q <= 1'b0;
                  if (col_q == COL_LAST) begin
                     col_q   <= '0;
                     state_q <= ST_BLANK;
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            ST_BLANK: begin
               panel_addr_q <= row_q;
               panel_lat_q  <= 1'b1;
               cnt_q        <= '0;
               state_q      <= ST_LATCH;
            end
            ST_LATCH: begin
               if (cnt_q == LAT_LAST) begin
                  // Latch drops on the same edge that enables output: never both active
                  panel_lat_q  <= 1'b0;
                  panel_oe_n_q <= 1'b0;
                  cnt_q        <= '0;
`ifdef LED_MATRIX_BRIGHT_EN
                  on_last_q    <= CNT_W'(bright_cycles(ON_CYC, brightness) - 1);
`endif
                  state_q      <= ST_DISPLAY;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DISPLAY: begin
               if (cnt_q == on_last) begin
                  // en is only honoured here so a row is never left half latched
                  panel_oe_n_q <= 1'b1;
                  row_q        <= row_q + 1'b1;
                  frame_done_q <= (row_q == ROW_LAST);
                  cnt_q        <= '0;
                  state_q      <= en ? ST_SHIFT : ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               panel_oe_n_q <= 1'b1;
               panel_lat_q  <= 1'b0;
            end
         endcase
      end
   end

   assign col        = col_q;
   assign row        = row_q;
   assign panel_r0   = data_q.r0;
   assign panel_g0   = data_q.g0;
   assign panel_b0   = data_q.b0;
   assign panel_r1   = data_q.r1;
   assign panel_g1   = data_q.g1;
   assign panel_b1   = data_q.b1;
   assign panel_clk  = panel_clk_q;
   assign panel_lat  = panel_lat_q;
   assign panel_oe_n = panel_oe_n_q;
   assign panel_addr = panel_addr_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- HUB75-style LED panel scan driver; it sits at the opposite end of the pixel interface from matrix_generate.
- It drives the column/row coordinate that the pixel generator consumes and samples the returned upper/lower-half RGB bits (R0/G0/B0, R1/G1/B1).
- It serialises those bits to the panel together with panel clock, latch, output-enable and row address.
- Scan is row-sequential: shift a row, blank, latch, display, advance.

Parameters:
- COLS, 64, columns shifted per scan row (power of 2, ≥4).
- ROW_BITS, 4, scan-row address width (16 scan rows; 1/16 scan).
- CLK_DIV, 2, system cycles per panel_clk half-period (≥1).
- LAT_CYC, 2, cycles panel_lat held high (≥1).
- ON_CYC, 256, cycles panel_oe_n held low per row (≥8).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable.
- col  out  $clog2(COLS)  column coordinate to pixel generator.
- row  out  ROW_BITS  scan row coordinate to pixel generator.
- R0,G0,B0,R1,G1,B1  in  1 each  pixel bits for (col,row) upper/lower half; combinational from col/row.
- panel_r0,panel_g0,panel_b0,panel_r1,panel_g1,panel_b1  out  1 each  serial data to panel.
- panel_clk  out  1  panel shift clock.
- panel_lat  out  1  panel latch, active-high.
- panel_oe_n  out  1  panel output enable, active-low.
- panel_addr  out  ROW_BITS  displayed row address.
- frame_done  out  1  one-cycle pulse when the last row finishes DISPLAY.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, col=0, row=0, all panel_r*/g*/b*=0, panel_clk=0, panel_lat=0, panel_oe_n=1, panel_addr=0, frame_done=0, phase counter=0.
- FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY. All outputs are registered.
- IDLE: panel_oe_n=1. Goes to SHIFT when en=1, starting at col=0 with the current row.
- SHIFT: uses phase counter ph = 0..2*CLK_DIV-1, one sweep per column.
  - ph==0: capture the six RGB inputs into the panel data registers, so they appear on the pins next cycle. panel_clk=0.
  - ph==CLK_DIV: panel_clk=1 (rising edge mid-period; data stable ≥CLK_DIV-1 cycles before it).
  - ph==2*CLK_DIV-1: panel_clk returns to 0 next cycle. col increments, wrapping to 0 after COLS-1.
  - After column COLS-1 completes: go to BLANK.
  - One column = 2*CLK_DIV cycles; row shift = COLS*2*CLK_DIV cycles.
  - col/row are held stable for the whole column period. The generator is combinational, so zero-cycle sampling at ph==0 is valid.
- BLANK: 1 cycle. panel_oe_n=1, panel_addr<=row. Then go to LATCH.
- LATCH: panel_lat=1 for LAT_CYC cycles, then 0. Then go to DISPLAY.
- DISPLAY: panel_oe_n=0 for ON_CYC cycles, then 1.
  - At exit, row increments (wraps 2^ROW_BITS-1 → 0).
  - frame_done pulses on the exit cycle when the displayed row == 2^ROW_BITS-1.
  - Next state: SHIFT if en=1, else IDLE.
- panel_oe_n=1 in every state except DISPLAY. panel_lat=0 except in LATCH. panel_lat and panel_oe_n are never both active.
- en deasserted mid-row: the current row completes through DISPLAY; only then does the FSM go to IDLE (no truncated latch).
- en reasserted while in IDLE: resumes at the held row value. Row does not reset on idle.
- Reset mid-operation: immediate return to reset values. panel_oe_n=1 asynchronously, so the panel is blanked.

Optional Feature:
- Macro: LED_MATRIX_BRIGHT_EN.
- Defined: adds input port brightness [2:0]. DISPLAY length = (ON_CYC>>3)*(brightness+1) cycles. brightness is sampled on entry to DISPLAY; changes during DISPLAY take effect next row.
- Undefined: no brightness port; DISPLAY length = ON_CYC.

Decomposition:
- Shared package led_matrix_pkg holds:
  - state enum (IDLE, SHIFT, BLANK, LATCH, DISPLAY);
  - default geometry constants (COLS=64, ROW_BITS=4);
  - an RGB-pair struct {r0,g0,b0,r1,g1,b1}, also usable by the pixel generator.
- Natural sub-module: led_clk_phase — the CLK_DIV phase counter emitting clk_rise / col_step strobes.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=0 with en=1 → panel_oe_n=1, panel_lat=0, col=0, row=0, all data 0. Assert rst=0 mid-DISPLAY → panel_oe_n=1 in the same cycle.
- Shift timing (COLS=64, CLK_DIV=2), generator model R0=col[0], B1=row[0]:
  - exactly 64 panel_clk rising edges per row, each 4 cycles apart;
  - panel_r0 at rising edge k equals k[0];
  - panel_lat rises 1 cycle after the last falling edge plus BLANK.
- Row sequencing: run 16 rows →
  - panel_addr steps 0..15;
  - panel_oe_n low for exactly 256 cycles per row, never overlapping panel_lat;
  - frame_done single pulse after row 15, then row wraps to 0.
- en drop: deassert en at column 10 of row 3 → row 3 still shifts 64 columns, latches and displays; then IDLE with panel_oe_n=1 and row=4. Reassert en → resumes at row 4.
- LED_MATRIX_BRIGHT_EN with ON_CYC=256:
  - brightness=0 → 32-cycle on-time;
  - brightness=7 → 256 cycles;
  - a change from 3→5 during DISPLAY → current row 128 cycles, next row 192.
- Config CLK_DIV=1, LAT_CYC=1, COLS=4 → 8-cycle shift, 1-cycle latch; no dropped or extra panel_clk edges.
